shift_rows_stream: RTL
======================

# shift_rows_stream

Parametrised, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It accepts one state per cycle over a valid/ready interface and applies the forward or inverse row rotation, selected per transaction, for Rijndael block widths of 4, 6 or 8 columns. The result is registered behind a 2-entry skid buffer so that the stage sits between SubBytes and MixColumns in a pipelined round without breaking throughput or back-pressure.

## Interface
Parameters:
- `NB`, default 4: number of 32-bit state columns. Legal values are 4, 6 and 8; any other value is an elaboration error.
- `TAG_W`, default 4: width of the sideband tag carried alongside each state.

Ports:
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input state present.
- `in_ready`  out  1  stage can accept the input.
- `in_data`  in  32*NB  input state. Byte (row r, column c) is at bits [32c+8r+7 : 32c+8r].
- `in_inv`  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the data.
- `in_tag`  in  TAG_W  sideband, passed through unchanged.
- `out_valid`  out  1  output state present.
- `out_ready`  in  1  downstream accepts the output.
- `out_data`  out  32*NB  rotated state, same byte layout as `in_data`.
- `out_tag`  out  TAG_W  tag of the state on `out_data`.
- `occupancy`  out  2  number of states held (0 to 2).

## Operation
- **Row offsets s_r** for rows 0 to 3:
  - NB=4 or NB=6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- **Forward:** out(r,c) = in(r, (c + s_r) mod NB).
- **Inverse:** out(r,c) = in(r, (c − s_r + NB) mod NB). Compute the modulo on column indices so the wrap-around is correct for NB=6.
- **Rotation timing:** the rotation is combinational on the input side and is captured at the input handshake. The stored `in_inv` value is not needed after that.
- **Storage:** two entries, a main output register and a skid register, each holding {data, tag, valid}.
- **States:**
  - EMPTY (occupancy 0).
  - ONE (main valid).
  - FULL (main and skid valid).
- **Transfers:** input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`.
- **Transitions:**
  - EMPTY + in fire → ONE.
  - ONE + in fire, no out fire → FULL; the new state goes to the skid.
  - ONE + in fire + out fire → ONE; main loads the new state.
  - ONE + out fire, no in fire → EMPTY.
  - FULL + out fire → ONE; skid moves to main.
- **FULL behaviour:** in FULL, `in_ready` = 0, so no input fire can occur.
- **Ordering:** states leave in acceptance order. Tags stay paired with their data.
- **Output stability:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_tag` hold stable.
- **Reset:** asynchronous assertion empties both entries immediately, discarding any in-flight states with no output transfer. Data and tag registers also clear to 0.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `out_tag` = 0, `occupancy` = 0.
  - `in_ready` = 0 while `rst` is high; `in_ready` = 1 in the first cycle after release.
- **Latency:** a state accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N (1 cycle) when EMPTY, or when ONE with a simultaneous out fire.
- **Throughput:** 1 state/cycle sustained while `out_ready` = 1.
- **`in_ready`:** equals `~skid_valid & ~rst`. It depends only on registered state and `rst`, never combinationally on `out_ready`.
- **Back-pressure:** after `out_ready` drops, at most one more input is accepted (into the skid). `in_ready` falls on the following edge.
- **`occupancy`:** registered; updates on the same edge as the transfers.

## Test plan
- **NB=4 forward (FIPS-197 App. B, round 1):** `in_data` = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4 with `in_inv` = 0, `in_tag` = 5 → one cycle later `out_data` = 128'he598271e_f11141b8_ae52b4e0_305dbfd4, `out_tag` = 5.
- **NB=4 inverse:** `in_data` = 128'he598271e_f11141b8_ae52b4e0_305dbfd4 with `in_inv` = 1 → `out_data` = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4.
- **NB=8 forward:** byte j = j (j = 0..31), `in_inv` = 0 → out column 0 word = 32'h130e0500. Feeding that output back with `in_inv` = 1 restores the input exactly. Repeat the round-trip for NB=6 with random data.
- **Back-pressure:** hold `out_ready` = 0 and present 3 states with tags 1, 2, 3 → tags 1 and 2 accepted, `occupancy` = 2, `in_ready` = 0, tag 3 stalled. Raise `out_ready` → outputs appear in the order 1, 2, 3, with no loss and no duplication.
- **Streaming:** `in_valid` = `out_ready` = 1 for 100 cycles with random data, mixed `in_inv` and random tags → 100 outputs on consecutive cycles, each matching the reference model.
- **Reset mid-operation:** reach FULL, then assert `rst` asynchronously between edges → `out_valid` and `occupancy` go to 0 immediately. After release, `in_ready` = 1 and the next state has 1-cycle latency.

Source files
------------

// File: rtl/shift_rows_stream.sv
// ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8 columns.
// The rotated state is captured into a 2-entry skid buffer behind a valid/ready handshake.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_data,
    input  logic                in_inv,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [1:0]          occupancy
);

    localparam int W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_main_data;
    logic [TAG_W-1:0]   r_main_tag;
    logic [W-1:0]       r_skid_data;
    logic [TAG_W-1:0]   r_skid_tag;
    logic [W-1:0]       w_rot;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_ld_main_in;
    logic               w_ld_main_skid;
    logic               w_ld_skid;

    // Rijndael widens the row-2/3 offsets by one for 8-column blocks.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Inverse source index adds NB before the modulo so it never goes negative.
    always_comb begin
        w_rot = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (in_inv)
                    w_rot[32*c+8*r +: 8] = in_data[32*((c - row_shift(r) + NB) % NB) + 8*r +: 8];
                else
                    w_rot[32*c+8*r +: 8] = in_data[32*((c + row_shift(r)) % NB) + 8*r +: 8];
            end
        end
    end

    assign out_valid  = (r_state != S_EMPTY);
    assign in_ready   = (r_state != S_FULL) & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign out_data   = r_main_data;
    assign out_tag    = r_main_tag;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        occupancy      = 2'd0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt  = S_ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            S_ONE: begin
                occupancy = 2'd1;
                if (w_in_fire && w_out_fire) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = S_FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                occupancy = 2'd2;
                if (w_out_fire) begin
                    w_state_nxt    = S_ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_main_tag  <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_main_in) begin
                r_main_data <= w_rot;
                r_main_tag  <= in_tag;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_tag  <= r_skid_tag;
            end
            if (w_ld_skid) begin
                r_skid_data <= w_rot;
                r_skid_tag  <= in_tag;
            end
        end
    end

endmodule
